maj_sweep_ctrl: RTL and testbench

MAJ_SWEEP_CTRL -- requirements
Module: maj_sweep_ctrl

---
 rtl/maj_sweep_ctrl.sv | 176 +++++++++++++++++
 tb/tb_maj_sweep_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maj_sweep_ctrl.sv
// maj_sweep_ctrl: walks all 128 patterns of a 7-input function through an
// external evaluator and assembles its truth table and onset size.
// Latency: start at edge T gives res_valid from cycle T+129+EVAL_LAT; the sweep never stalls.
// Backpressure: the result is held in DONE until res_valid & res_ready.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start, abort       - begin a sweep (IDLE only) / cancel (SWEEP or DRAIN only)
//   x_out, x_valid     - pattern issued to the evaluator
//   f_in               - evaluator result, EVAL_LAT cycles behind x_out
//   busy               - sweep in progress or result pending
//   tt, ones_cnt       - truth table (bit i = f(i)) and its popcount
//   res_valid, res_ready - result handshake
module maj_sweep_ctrl #(
    parameter int EVAL_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    output logic [6:0]   x_out,
    output logic         x_valid,
    input  logic         f_in,
    output logic         busy,
    output logic [127:0] tt,
    output logic [7:0]   ones_cnt,
    output logic         res_valid,
    input  logic         res_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Count value on the last DRAIN cycle; unused when EVAL_LAT is 0.
    localparam logic [1:0] DRAIN_LAST = (EVAL_LAT > 0) ? 2'(EVAL_LAT - 1) : 2'd0;

    state_t     state;
    state_t     state_nxt;
    logic [6:0] index;
    logic [1:0] drain_cnt;
    logic       flush;
    logic       cap_vld;
    logic [6:0] cap_idx;

    // Abort discards everything still in flight toward the evaluator.
    assign flush = abort && (state == SWEEP || state == DRAIN);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (index == 7'd127) begin
                    state_nxt = (EVAL_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        x_valid   = (state == SWEEP);
        x_out     = (state == SWEEP) ? index : 7'd0;
        busy      = (state != IDLE);
        res_valid = (state == DONE);
    end

    // ------------------------------------------------------------------
    // Delay line aligning (x_valid, index) with the evaluator output
    // ------------------------------------------------------------------
    if (EVAL_LAT == 0) begin : g_no_delay
        // Evaluator is combinational: capture in the issue cycle.
        assign cap_vld = x_valid;
        assign cap_idx = x_out;
    end else begin : g_delay
        logic [EVAL_LAT-1:0] dl_vld;
        logic [6:0]          dl_idx [EVAL_LAT];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                dl_vld <= '0;
            end else begin
                dl_vld[0] <= x_valid;
                for (int i = EVAL_LAT - 1; i > 0; i--) begin
                    dl_vld[i] <= dl_vld[i-1];
                end
            end
        end

        // Index stages need no reset: they are only consumed with their valid.
        always_ff @(posedge clk) begin
            dl_idx[0] <= x_out;
            for (int i = EVAL_LAT - 1; i > 0; i--) begin
                dl_idx[i] <= dl_idx[i-1];
            end
        end

        assign cap_vld = dl_vld[EVAL_LAT-1];
        assign cap_idx = dl_idx[EVAL_LAT-1];
    end

    // ------------------------------------------------------------------
    // Pattern index, drain counter and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            index     <= 7'd0;
            drain_cnt <= 2'd0;
            tt        <= '0;
            ones_cnt  <= 8'd0;
        end else begin
            if (state == IDLE && start) begin
                index    <= 7'd0;
                tt       <= '0;
                ones_cnt <= 8'd0;
            end else begin
                if (state == SWEEP) begin
                    index <= index + 7'd1;
                end
                if (cap_vld) begin
                    tt[cap_idx] <= f_in;
                    // Saturate: the count can never legitimately exceed 128.
                    if (f_in && ones_cnt != 8'd128) begin
                        ones_cnt <= ones_cnt + 8'd1;
                    end
                end
            end

            if (state == SWEEP) begin
                drain_cnt <= 2'd0;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_maj_sweep_ctrl.sv
module tb_maj_sweep_ctrl;

    logic         clk;
    logic         rst;
    logic         start_s     [2];
    logic         abort_s     [2];
    logic [6:0]   x_out_s     [2];
    logic         x_valid_s   [2];
    logic         f_in_s      [2];
    logic         busy_s      [2];
    logic [127:0] tt_s        [2];
    logic [7:0]   ones_s      [2];
    logic         res_valid_s [2];
    logic         res_ready_s [2];

    int           f_sel [2];
    logic [127:0] rnd_tt;
    logic         fp1;
    logic         fp2;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: combinational evaluator. Instance 1: two-stage evaluator.
    maj_sweep_ctrl #(.EVAL_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
        .x_out(x_out_s[0]), .x_valid(x_valid_s[0]), .f_in(f_in_s[0]),
        .busy(busy_s[0]), .tt(tt_s[0]), .ones_cnt(ones_s[0]),
        .res_valid(res_valid_s[0]), .res_ready(res_ready_s[0])
    );

    maj_sweep_ctrl #(.EVAL_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
        .x_out(x_out_s[1]), .x_valid(x_valid_s[1]), .f_in(f_in_s[1]),
        .busy(busy_s[1]), .tt(tt_s[1]), .ones_cnt(ones_s[1]),
        .res_valid(res_valid_s[1]), .res_ready(res_ready_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fn(input int sel, input logic [6:0] x, input logic [127:0] tbl);
        case (sel)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return x[0];
            3:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
            default: return tbl[x];
        endcase
    endfunction

    always_comb f_in_s[0] = fn(f_sel[0], x_out_s[0], rnd_tt);

    always @(posedge clk) begin
        fp1 <= fn(f_sel[1], x_out_s[1], rnd_tt);
        fp2 <= fp1;
    end
    always_comb f_in_s[1] = fp2;

    // Sweep with reference checking. Called and returns just after a negedge.
    task automatic run_sweep(input int d, input int sel, input int hold, input bit noise);
        int           lat;
        int           first_rv;
        int           k;
        int           exp_ones;
        bit           xbad;
        bit           unstable;
        int           bad_k;
        logic [127:0] exp_tt;
        logic [127:0] tt_snap;
        logic [7:0]   ones_snap;
        lat      = (d == 0) ? 0 : 2;
        f_sel[d] = sel;
        exp_tt   = '0;
        exp_ones = 0;
        for (int i = 0; i < 128; i++) begin
            exp_tt[i] = fn(sel, 7'(i), rnd_tt);
            if (exp_tt[i]) exp_ones++;
        end
        start_s[d]     = 1'b1;
        res_ready_s[d] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        start_s[d] = 1'b0;
        first_rv = 0;
        xbad     = 1'b0;
        bad_k    = 0;
        k        = 1;
        while (first_rv == 0 && k < 400) begin
            if (res_valid_s[d] === 1'b1) begin
                first_rv = k;
            end else begin
                if (k <= 128) begin
                    if (!(x_valid_s[d] === 1'b1 && x_out_s[d] === 7'(k - 1))) begin
                        if (!xbad) bad_k = k;
                        xbad = 1'b1;
                    end
                end else if (x_valid_s[d] !== 1'b0 || busy_s[d] !== 1'b1) begin
                    if (!xbad) bad_k = k;
                    xbad = 1'b1;
                end
                if (noise) start_s[d] = 1'($urandom % 2);
                @(negedge clk);
                k++;
            end
        end
        n_checks++;
        if (xbad) begin
            n_fail++;
            $display("FAIL xseq dut%0d: pattern stream wrong at cycle %0d (x_out=%0d x_valid=%b busy=%b)",
                     d, bad_k, x_out_s[d], x_valid_s[d], busy_s[d]);
        end
        n_checks++;
        if (first_rv != 129 + lat) begin
            n_fail++;
            $display("FAIL latency dut%0d: res_valid at T+%0d, required T+%0d (0 = never)", d, first_rv, 129 + lat);
        end
        n_checks++;
        if (tt_s[d] !== exp_tt) begin
            n_fail++;
            $display("FAIL tt dut%0d sel%0d: got %h required %h", d, sel, tt_s[d], exp_tt);
        end
        n_checks++;
        if (ones_s[d] !== 8'(exp_ones)) begin
            n_fail++;
            $display("FAIL ones_cnt dut%0d sel%0d: got %0d required %0d", d, sel, ones_s[d], exp_ones);
        end
        if (hold > 0) begin
            tt_snap   = tt_s[d];
            ones_snap = ones_s[d];
            unstable  = 1'b0;
            repeat (hold) begin
                start_s[d] = 1'($urandom % 2);
                abort_s[d] = 1'($urandom % 2);
                @(negedge clk);
                if (res_valid_s[d] !== 1'b1 || busy_s[d] !== 1'b1 ||
                    tt_s[d] !== tt_snap || ones_s[d] !== ones_snap) unstable = 1'b1;
            end
            n_checks++;
            if (unstable) begin
                n_fail++;
                $display("FAIL hold dut%0d: result not stable while res_ready low (res_valid=%b ones=%0d, required 1 and %0d)",
                         d, res_valid_s[d], ones_s[d], ones_snap);
            end
            abort_s[d]     = 1'b0;
            res_ready_s[d] = 1'b1;
        end
        // Handshake cycle: a start here must be ignored.
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d]     = 1'b0;
        res_ready_s[d] = 1'b0;
        n_checks++;
        if (res_valid_s[d] !== 1'b0 || busy_s[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake dut%0d: res_valid=%b busy=%b, required 0 0", d, res_valid_s[d], busy_s[d]);
        end
        n_checks++;
        if (tt_s[d] !== exp_tt || ones_s[d] !== 8'(exp_ones)) begin
            n_fail++;
            $display("FAIL retain dut%0d: tt=%h ones=%0d, required %h %0d", d, tt_s[d], ones_s[d], exp_tt, exp_ones);
        end
    endtask

    task automatic check_reset_vals(input int d);
        n_checks++;
        if (x_out_s[d] !== 7'd0 || x_valid_s[d] !== 1'b0 || busy_s[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl dut%0d: x_out=%0d x_valid=%b busy=%b, required 0 0 0",
                     d, x_out_s[d], x_valid_s[d], busy_s[d]);
        end
        n_checks++;
        if (tt_s[d] !== 128'd0 || ones_s[d] !== 8'd0 || res_valid_s[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_res dut%0d: tt=%h ones=%0d res_valid=%b, required 0 0 0",
                     d, tt_s[d], ones_s[d], res_valid_s[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_sweep(0, 2, 0, 1'b0);   // f = x0
        run_sweep(1, 3, 0, 1'b0);   // f = maj(x0,x1,x2)
    endtask

    task automatic test_backpressure();
        run_sweep(0, 1, 10, 1'b0);
        run_sweep(1, 1, 10, 1'b0);
    endtask

    task automatic wait_x(input int d, input int val);
        int k;
        k = 0;
        while (x_out_s[d] !== 7'(val) && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (x_out_s[d] !== 7'(val)) begin
            n_fail++;
            $display("FAIL reach_x dut%0d: x_out=%0d, required %0d", d, x_out_s[d], val);
        end
    endtask

    task automatic expect_no_result(input int d, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (res_valid_s[d] !== 1'b0 || busy_s[d] !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL stray dut%0d: activity after abort, res_valid=%b busy=%b required 0 0",
                     d, res_valid_s[d], busy_s[d]);
        end
    endtask

    task automatic test_abort(input int d);
        f_sel[d]   = 1;
        start_s[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[d] = 1'b0;
        wait_x(d, 50);
        abort_s[d] = 1'b1;
        @(negedge clk);
        abort_s[d] = 1'b0;
        n_checks++;
        if (busy_s[d] !== 1'b0 || x_valid_s[d] !== 1'b0 || x_out_s[d] !== 7'd0) begin
            n_fail++;
            $display("FAIL abort dut%0d: busy=%b x_valid=%b x_out=%0d, required 0 0 0",
                     d, busy_s[d], x_valid_s[d], x_out_s[d]);
        end
        expect_no_result(d, 140);
        if (d == 1) begin
            // start and abort together in IDLE: start wins.
            start_s[d] = 1'b1;
            abort_s[d] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_s[d] = 1'b0;
            abort_s[d] = 1'b0;
            n_checks++;
            if (x_valid_s[d] !== 1'b1 || x_out_s[d] !== 7'd0) begin
                n_fail++;
                $display("FAIL start_wins dut%0d: x_valid=%b x_out=%0d, required 1 0", d, x_valid_s[d], x_out_s[d]);
            end
            wait_x(d, 127);
            @(negedge clk);   // first DRAIN cycle
            abort_s[d] = 1'b1;
            @(negedge clk);
            abort_s[d] = 1'b0;
            n_checks++;
            if (busy_s[d] !== 1'b0 || res_valid_s[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_abort dut%0d: busy=%b res_valid=%b, required 0 0", d, busy_s[d], res_valid_s[d]);
            end
            expect_no_result(d, 10);
        end
        run_sweep(d, 0, 0, 1'b0);
    endtask

    task automatic test_rst_mid(input int d);
        f_sel[d]   = 1;
        start_s[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[d] = 1'b0;
        wait_x(d, 90);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals(d);
        rst = 1'b0;
        // Start in the very first cycle after reset release, with noise.
        run_sweep(d, 3 - d, 3, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            rnd_tt = {$urandom, $urandom, $urandom, $urandom};
            run_sweep(int'($urandom % 2), 4, int'($urandom_range(0, 12)), 1'b1);
        end
    endtask

    initial begin
        rst    = 1'b1;
        rnd_tt = '0;
        for (int d = 0; d < 2; d++) begin
            start_s[d]     = 1'b0;
            abort_s[d]     = 1'b0;
            res_ready_s[d] = 1'b0;
            f_sel[d]       = 0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_abort(0);
        test_abort(1);
        test_rst_mid(0);
        test_rst_mid(1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
